// File: rtl/lif_param_loader_mc_pkg.sv
// lif_pkg: shared types and constants for the LIF multi-channel parameter loader.
// Build option: LIF_LOADER_PARITY_EN adds a trailing even-parity bit and a PARITY state.
package lif_pkg;

`ifdef LIF_LOADER_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_LOAD_W    = 3'd2,
    ST_LOAD_LEAK = 3'd3,
    ST_LOAD_THR  = 3'd4,
    ST_PARITY    = 3'd5
  } lif_state_e;
  localparam int LIF_PARITY_BITS = 1;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_LOAD_W    = 3'd2,
    ST_LOAD_LEAK = 3'd3,
    ST_LOAD_THR  = 3'd4
  } lif_state_e;
  localparam int LIF_PARITY_BITS = 0;
`endif

  // Per-channel power-on parameter values
  localparam int LIF_DEFAULT_W    = 2;
  localparam int LIF_DEFAULT_LEAK = 1;
  localparam int LIF_DEFAULT_THR  = 30;

  // Total serial frame length in bits (broadcast + address + fields + optional parity)
  function automatic int lif_frame_len(input int addr_bits, input int w_bits,
                                       input int leak_bits, input int thr_bits);
    return 1 + addr_bits + w_bits + leak_bits + thr_bits + LIF_PARITY_BITS;
  endfunction

  // Widest of the four frame sections; sizes the shared shift register
  function automatic int lif_max_field(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lif_param_loader_mc_if.sv
// Serial configuration port plus the per-channel parameter outputs of the LIF loader.
// master = configuration host, slave = loader.
interface lif_param_loader_mc_if #(
  parameter int NUM_CH    = 4,
  parameter int W_BITS    = 3,
  parameter int LEAK_BITS = 2,
  parameter int THR_BITS  = 8
) ();
  logic                          enable;
  logic                          serial_data_in;
  logic                          load_enable;
  logic [NUM_CH*W_BITS-1:0]      weight;
  logic [NUM_CH*LEAK_BITS-1:0]   leak_config;
  logic [NUM_CH*THR_BITS-1:0]    threshold;
  logic [NUM_CH-1:0]             params_ready;
  logic                          load_done;
  logic                          load_error;
  logic                          busy;

  modport master (
    output enable, serial_data_in, load_enable,
    input  weight, leak_config, threshold, params_ready, load_done, load_error, busy
  );

  modport slave (
    input  enable, serial_data_in, load_enable,
    output weight, leak_config, threshold, params_ready, load_done, load_error, busy
  );
endinterface

// File: rtl/lif_param_loader_mc_bank.sv
// lif_param_bank: live per-channel parameter registers and params_ready flags.
// A write lands on one channel or on all channels (broadcast) and always
// re-asserts every ready flag, as does a restore after a discarded frame.
module lif_param_bank
  import lif_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int ADDR_BITS    = 2,
  parameter int W_BITS       = 3,
  parameter int LEAK_BITS    = 2,
  parameter int THR_BITS     = 8,
  parameter int DEFAULT_W    = LIF_DEFAULT_W,
  parameter int DEFAULT_LEAK = LIF_DEFAULT_LEAK,
  parameter int DEFAULT_THR  = LIF_DEFAULT_THR
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic                        wr_bcast,
  input  logic [ADDR_BITS-1:0]        wr_addr,
  input  logic [W_BITS-1:0]           wr_w,
  input  logic [LEAK_BITS-1:0]        wr_leak,
  input  logic [THR_BITS-1:0]         wr_thr,
  input  logic                        clr_en,
  input  logic                        clr_bcast,
  input  logic [ADDR_BITS-1:0]        clr_addr,
  input  logic                        rdy_set,
  output logic [NUM_CH*W_BITS-1:0]    weight,
  output logic [NUM_CH*LEAK_BITS-1:0] leak_config,
  output logic [NUM_CH*THR_BITS-1:0]  threshold,
  output logic [NUM_CH-1:0]           params_ready
);
  logic [NUM_CH*W_BITS-1:0]    weight_r;
  logic [NUM_CH*LEAK_BITS-1:0] leak_r;
  logic [NUM_CH*THR_BITS-1:0]  thr_r;
  logic [NUM_CH-1:0]           ready_r;
  logic [NUM_CH-1:0]           wr_sel_s;
  logic [NUM_CH-1:0]           clr_sel_s;

  // Channel select decode for writes and ready-clears (one-hot or all)
  always_comb begin
    wr_sel_s  = '0;
    clr_sel_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_sel_s[c]  = wr_bcast  | (wr_addr  == ADDR_BITS'(c));
      clr_sel_s[c] = clr_bcast | (clr_addr == ADDR_BITS'(c));
    end
  end

  // Live parameter registers and ready flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        weight_r[c*W_BITS +: W_BITS]       <= W_BITS'(DEFAULT_W);
        leak_r[c*LEAK_BITS +: LEAK_BITS]   <= LEAK_BITS'(DEFAULT_LEAK);
        thr_r[c*THR_BITS +: THR_BITS]      <= THR_BITS'(DEFAULT_THR);
      end
      ready_r <= '1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_en && wr_sel_s[c]) begin
          weight_r[c*W_BITS +: W_BITS]     <= wr_w;
          leak_r[c*LEAK_BITS +: LEAK_BITS] <= wr_leak;
          thr_r[c*THR_BITS +: THR_BITS]    <= wr_thr;
        end
      end
      if (wr_en || rdy_set) begin
        ready_r <= '1;
      end else if (clr_en) begin
        ready_r <= ready_r & ~clr_sel_s;
      end else begin
        ready_r <= ready_r;
      end
    end
  end

  assign weight       = weight_r;
  assign leak_config  = leak_r;
  assign threshold    = thr_r;
  assign params_ready = ready_r;

endmodule

// File: rtl/lif_param_loader_mc.sv
// lif_param_loader_mc: serial frame receiver that commits weight/leak/threshold
// atomically to one LIF channel or to all channels (broadcast).
// Build option: LIF_LOADER_PARITY_EN appends an even-parity bit to every frame.
// Commit is registered one cycle after the last frame bit, so busy covers that
// pending cycle and falls together with the parameter update.
module lif_param_loader_mc
  import lif_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int W_BITS       = 3,
  parameter int LEAK_BITS    = 2,
  parameter int THR_BITS     = 8,
  parameter int DEFAULT_W    = LIF_DEFAULT_W,
  parameter int DEFAULT_LEAK = LIF_DEFAULT_LEAK,
  parameter int DEFAULT_THR  = LIF_DEFAULT_THR
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lif_param_loader_mc_if.slave bus
);
  localparam int ADDR_BITS = $clog2(NUM_CH);
  localparam int HDR_BITS  = 1 + ADDR_BITS;
  localparam int SR_W      = lif_max_field(HDR_BITS, W_BITS, LEAK_BITS, THR_BITS);
  localparam int CNT_W     = $clog2(SR_W);
  localparam logic [ADDR_BITS:0] NUM_CH_L = (ADDR_BITS+1)'(NUM_CH);
`ifdef LIF_LOADER_PARITY_EN
  localparam lif_state_e LAST_ST = ST_PARITY;
`else
  localparam lif_state_e LAST_ST = ST_LOAD_THR;
`endif

  lif_state_e             state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [SR_W-2:0]        sr_r;
  logic                   le_q_r;
  logic                   bcast_r;
  logic [ADDR_BITS-1:0]   addr_r;
  logic                   invalid_r;
  logic [W_BITS-1:0]      sh_w_r;
  logic [LEAK_BITS-1:0]   sh_leak_r;
  logic [THR_BITS-1:0]    sh_thr_r;
  logic                   commit_pend_r;
  logic                   busy_r;
  logic                   load_done_r;
  logic                   load_error_r;
`ifdef LIF_LOADER_PARITY_EN
  logic                   par_r;
`endif

  logic [SR_W-1:0]        nxt_sr_s;
  logic                   rise_s;
  logic                   abort_s;
  logic                   shift_s;
  logic                   field_last_s;
  logic                   hdr_done_s;
  logic                   hdr_invalid_s;
  logic                   frame_last_s;
  logic                   reject_s;
  logic                   wr_en_s;
  logic                   clr_en_s;
  logic                   rdy_restore_s;

  // Frame decode: edge detect, field-end detect, commit/reject and bank controls
  always_comb begin
    nxt_sr_s      = {sr_r, bus.serial_data_in};
    shift_s       = bus.enable & bus.load_enable & (state_r != ST_IDLE);
    rise_s        = bus.enable & bus.load_enable & ~le_q_r & (state_r == ST_IDLE);
    abort_s       = bus.enable & ~bus.load_enable & (state_r != ST_IDLE);
    hdr_invalid_s = ~nxt_sr_s[ADDR_BITS] & ({1'b0, nxt_sr_s[ADDR_BITS-1:0]} >= NUM_CH_L);
    case (state_r)
      ST_HDR:       field_last_s = (cnt_r == CNT_W'(HDR_BITS - 1));
      ST_LOAD_W:    field_last_s = (cnt_r == CNT_W'(W_BITS - 1));
      ST_LOAD_LEAK: field_last_s = (cnt_r == CNT_W'(LEAK_BITS - 1));
      ST_LOAD_THR:  field_last_s = (cnt_r == CNT_W'(THR_BITS - 1));
`ifdef LIF_LOADER_PARITY_EN
      ST_PARITY:    field_last_s = 1'b1;
`endif
      default:      field_last_s = 1'b0;
    endcase
    hdr_done_s   = shift_s & (state_r == ST_HDR) & field_last_s;
    frame_last_s = shift_s & (state_r == LAST_ST) & field_last_s;
`ifdef LIF_LOADER_PARITY_EN
    reject_s     = invalid_r | (par_r ^ bus.serial_data_in);
`else
    reject_s     = invalid_r;
`endif
    wr_en_s       = bus.enable & commit_pend_r;
    clr_en_s      = hdr_done_s & ~hdr_invalid_s;
    rdy_restore_s = abort_s | (frame_last_s & reject_s);
  end

  // Frame FSM with shift register, field counter, shadow fields and status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      sr_r          <= '0;
      le_q_r        <= 1'b0;
      bcast_r       <= 1'b0;
      addr_r        <= '0;
      invalid_r     <= 1'b0;
      sh_w_r        <= '0;
      sh_leak_r     <= '0;
      sh_thr_r      <= '0;
      commit_pend_r <= 1'b0;
      busy_r        <= 1'b0;
      load_done_r   <= 1'b0;
      load_error_r  <= 1'b0;
`ifdef LIF_LOADER_PARITY_EN
      par_r         <= 1'b0;
`endif
    end else if (bus.enable) begin
      le_q_r        <= bus.load_enable;
      load_done_r   <= commit_pend_r;
      load_error_r  <= 1'b0;
      commit_pend_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_r   <= ST_HDR;
            cnt_r     <= '0;
            sr_r      <= '0;
            invalid_r <= 1'b0;
            busy_r    <= 1'b1;
`ifdef LIF_LOADER_PARITY_EN
            par_r     <= 1'b0;
`endif
          end else begin
            busy_r    <= 1'b0;
          end
        end
        default: begin
          if (abort_s) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            busy_r       <= 1'b0;
            load_error_r <= 1'b1;
          end else begin
            sr_r <= nxt_sr_s[SR_W-2:0];
`ifdef LIF_LOADER_PARITY_EN
            par_r <= par_r ^ bus.serial_data_in;
`endif
            if (!field_last_s) begin
              cnt_r <= cnt_r + 1'b1;
            end else begin
              cnt_r <= '0;
              case (state_r)
                ST_HDR: begin
                  bcast_r   <= nxt_sr_s[ADDR_BITS];
                  addr_r    <= nxt_sr_s[ADDR_BITS-1:0];
                  invalid_r <= hdr_invalid_s;
                  state_r   <= ST_LOAD_W;
                end
                ST_LOAD_W: begin
                  sh_w_r  <= nxt_sr_s[W_BITS-1:0];
                  state_r <= ST_LOAD_LEAK;
                end
                ST_LOAD_LEAK: begin
                  sh_leak_r <= nxt_sr_s[LEAK_BITS-1:0];
                  state_r   <= ST_LOAD_THR;
                end
`ifdef LIF_LOADER_PARITY_EN
                ST_LOAD_THR: begin
                  sh_thr_r <= nxt_sr_s[THR_BITS-1:0];
                  state_r  <= ST_PARITY;
                end
                ST_PARITY: begin
                  state_r <= ST_IDLE;
                  if (reject_s) begin
                    busy_r       <= 1'b0;
                    load_error_r <= 1'b1;
                  end else begin
                    commit_pend_r <= 1'b1;
                  end
                end
`else
                ST_LOAD_THR: begin
                  sh_thr_r <= nxt_sr_s[THR_BITS-1:0];
                  state_r  <= ST_IDLE;
                  if (reject_s) begin
                    busy_r       <= 1'b0;
                    load_error_r <= 1'b1;
                  end else begin
                    commit_pend_r <= 1'b1;
                  end
                end
`endif
                default: begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  lif_param_bank #(
    .NUM_CH       (NUM_CH),
    .ADDR_BITS    (ADDR_BITS),
    .W_BITS       (W_BITS),
    .LEAK_BITS    (LEAK_BITS),
    .THR_BITS     (THR_BITS),
    .DEFAULT_W    (DEFAULT_W),
    .DEFAULT_LEAK (DEFAULT_LEAK),
    .DEFAULT_THR  (DEFAULT_THR)
  ) u_bank (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en_s),
    .wr_bcast     (bcast_r),
    .wr_addr      (addr_r),
    .wr_w         (sh_w_r),
    .wr_leak      (sh_leak_r),
    .wr_thr       (sh_thr_r),
    .clr_en       (clr_en_s),
    .clr_bcast    (nxt_sr_s[ADDR_BITS]),
    .clr_addr     (nxt_sr_s[ADDR_BITS-1:0]),
    .rdy_set      (rdy_restore_s),
    .weight       (bus.weight),
    .leak_config  (bus.leak_config),
    .threshold    (bus.threshold),
    .params_ready (bus.params_ready)
  );

  assign bus.busy       = busy_r;
  assign bus.load_done  = load_done_r;
  assign bus.load_error = load_error_r;

endmodule

// File: tb/tb_lif_param_loader_mc.sv
// Directed bench for lif_param_loader_mc (defaults: 4 channels, 3/2/8-bit fields).
// Parity cases are included when LIF_LOADER_PARITY_EN is defined.
module tb_lif_param_loader_mc;
  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lif_param_loader_mc_if #(.NUM_CH(4), .W_BITS(3), .LEAK_BITS(2), .THR_BITS(8)) bus ();

  lif_param_loader_mc #(
    .NUM_CH(4), .W_BITS(3), .LEAK_BITS(2), .THR_BITS(8),
    .DEFAULT_W(2), .DEFAULT_LEAK(1), .DEFAULT_THR(30)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.serial_data_in = f[i];
      tick();
    end
  endtask

  // Remaining data bits down to bit 0, then the correct parity bit when enabled
  task automatic finish_frame(input logic [15:0] f, input int hi);
    send_bits(f, hi, 0);
`ifdef LIF_LOADER_PARITY_EN
    bus.serial_data_in = ^f;
    tick();
`endif
  endtask

  task automatic open_frame();
    bus.load_enable = 1'b1;
    tick();
  endtask

  task automatic check_params(input string tag, input logic [11:0] w, input logic [7:0] l,
                              input logic [31:0] t, input logic [3:0] r);
    chk({tag, "_weight"}, {20'd0, bus.weight}, {20'd0, w});
    chk({tag, "_leak"}, {24'd0, bus.leak_config}, {24'd0, l});
    chk({tag, "_thr"}, bus.threshold, t);
    chk({tag, "_ready"}, {28'd0, bus.params_ready}, {28'd0, r});
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.enable         = 1'b1;
    bus.load_enable    = 1'b0;
    bus.serial_data_in = 1'b0;
    tick();
    tick();
    // Reset state
    check_params("reset", 12'h492, 8'h55, 32'h1E1E1E1E, 4'hF);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.load_done}, 32'd0);
    chk("reset_err", {31'd0, bus.load_error}, 32'd0);
    reset_n = 1'b1;
    tick();
    tick();

    // Unicast: channel 2 <= 5/3/100, frame 0|10|101|11|0x64
    open_frame();
    chk("uni_busy_rise", {31'd0, bus.busy}, 32'd1);
    send_bits(16'h5764, 15, 13);
    chk("uni_hdr_ready", {28'd0, bus.params_ready}, 32'hB);
    finish_frame(16'h5764, 12);
    chk("uni_last_done", {31'd0, bus.load_done}, 32'd0);
    chk("uni_last_busy", {31'd0, bus.busy}, 32'd1);
    chk("uni_last_weight", {20'd0, bus.weight}, 32'h492);
    tick();
    chk("uni_done", {31'd0, bus.load_done}, 32'd1);
    chk("uni_busy_fall", {31'd0, bus.busy}, 32'd0);
    check_params("uni", 12'h552, 8'h75, 32'h1E641E1E, 4'hF);
    tick();
    chk("uni_done_pulse", {31'd0, bus.load_done}, 32'd0);

    // Broadcast: all channels <= 3/0/15, frame 1|00|011|00|0x0F
    bus.load_enable = 1'b0;
    tick();
    open_frame();
    send_bits(16'h8C0F, 15, 13);
    chk("bc_hdr_ready", {28'd0, bus.params_ready}, 32'h0);
    finish_frame(16'h8C0F, 12);
    chk("bc_last_ready", {28'd0, bus.params_ready}, 32'h0);
    chk("bc_last_weight", {20'd0, bus.weight}, 32'h552);
    tick();
    chk("bc_done", {31'd0, bus.load_done}, 32'd1);
    check_params("bc", 12'h6DB, 8'h00, 32'h0F0F0F0F, 4'hF);

    // Abort: channel-1 frame dropped after 9 bits
    bus.load_enable = 1'b0;
    tick();
    open_frame();
    send_bits(16'h3AAA, 15, 7);
    chk("ab_mid_ready", {28'd0, bus.params_ready}, 32'hD);
    bus.load_enable = 1'b0;
    tick();
    chk("ab_err", {31'd0, bus.load_error}, 32'd1);
    chk("ab_busy", {31'd0, bus.busy}, 32'd0);
    check_params("ab", 12'h6DB, 8'h00, 32'h0F0F0F0F, 4'hF);
    tick();
    chk("ab_err_pulse", {31'd0, bus.load_error}, 32'd0);
    chk("ab_no_done", {31'd0, bus.load_done}, 32'd0);

    // Freeze: channel 0 <= 7/1/200 with enable low for 5 cycles mid-frame
    open_frame();
    send_bits(16'h1DC8, 15, 8);
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.serial_data_in = ~bus.serial_data_in;
      tick();
      chk("frz_busy_hold", {31'd0, bus.busy}, 32'd1);
    end
    bus.enable = 1'b1;
    finish_frame(16'h1DC8, 7);
    chk("frz_last_done", {31'd0, bus.load_done}, 32'd0);
    tick();
    chk("frz_done", {31'd0, bus.load_done}, 32'd1);
    check_params("frz", 12'h6DF, 8'h01, 32'h0F0F0FC8, 4'hF);

    // Re-arm: load_enable held high after commit must not start a frame
    for (int i = 0; i < 20; i++) begin
      bus.serial_data_in = i[0];
      tick();
      chk("rearm_busy", {31'd0, bus.busy}, 32'd0);
    end
    check_params("rearm", 12'h6DF, 8'h01, 32'h0F0F0FC8, 4'hF);

`ifdef LIF_LOADER_PARITY_EN
    // Parity good: channel 3 <= 1/2/1, commit visible F+2 cycles after the edge
    bus.load_enable = 1'b0;
    tick();
    open_frame();
    finish_frame(16'h6601, 15);
    chk("par_last_done", {31'd0, bus.load_done}, 32'd0);
    tick();
    chk("par_done", {31'd0, bus.load_done}, 32'd1);
    check_params("par", 12'h2DF, 8'h81, 32'h010F0FC8, 4'hF);
    // Parity flipped: discarded
    bus.load_enable = 1'b0;
    tick();
    open_frame();
    send_bits(16'h0000, 15, 0);
    bus.serial_data_in = 1'b1;
    tick();
    chk("parbad_err", {31'd0, bus.load_error}, 32'd1);
    tick();
    chk("parbad_no_done", {31'd0, bus.load_done}, 32'd0);
    check_params("parbad", 12'h2DF, 8'h81, 32'h010F0FC8, 4'hF);
`endif

    // Reset mid-frame: immediate return to defaults
    bus.load_enable = 1'b0;
    tick();
    open_frame();
    send_bits(16'h5764, 15, 11);
    #2;
    reset_n = 1'b0;
    #1;
    check_params("rst_mid", 12'h492, 8'h55, 32'h1E1E1E1E, 4'hF);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    bus.load_enable = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("rst_after_busy", {31'd0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
